instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL indicate that a fetch request is pending.
REQ-005 imem_addr  output  32  SHALL be the word-aligned fetch address, driven from a register.
REQ-006 imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle for the pending request.
REQ-007 imem_rdata  input  32  SHALL carry the instruction word returned by memory.
REQ-008 stall  input  1  SHALL be asserted by downstream logic to hold the current instruction.
REQ-009 redirect_valid  input  1  SHALL indicate that a taken branch or jump redirects fetch.
REQ-010 redirect_pc  input  32  SHALL be the redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 valid  output  1  SHALL indicate that instr and pc_out hold a live instruction.
REQ-012 instr, pc_out  output  32 each  SHALL be the registered instruction and its address.
REQ-013 opcode  output  6, funct  output  6, rs/rt/rd  output  5 each, imm  output  16  SHALL be combinational slices of instr: [31:26], [5:0], [25:21], [20:16], [15:11] and [15:0].

Function
REQ-014 The FSM SHALL have exactly three states: REQ, HOLD and DRAIN.
REQ-015 In REQ and DRAIN, imem_req SHALL be 1; in HOLD, imem_req SHALL be 0.
REQ-016 imem_addr SHALL remain stable while imem_req=1 and imem_ack=0.
REQ-017 In REQ with imem_ack=1 and redirect_valid=0, the unit SHALL load instr<=imem_rdata, pc_out<=imem_addr and valid<=1, and SHALL set pc<=imem_addr+4, with 32-bit wrap so that 0xFFFF_FFFC becomes 0.
REQ-018 The state transition after the REQ load in REQ-017 SHALL be to HOLD; valid SHALL rise in the cycle after the ack.
REQ-019 In HOLD with stall=1, all outputs SHALL remain unchanged.
REQ-020 In HOLD with stall=0, the unit SHALL clear valid, load imem_addr<=pc and enter REQ.
REQ-021 Any state with redirect_valid=1 SHALL set pc<=redirect_pc & ~3 and valid<=0.
REQ-022 Redirect from HOLD SHALL go to REQ and load imem_addr with the target.
REQ-023 Redirect in REQ with imem_ack=1 SHALL discard imem_rdata and go to REQ with imem_addr set to the target.
REQ-024 Redirect in REQ with imem_ack=0 SHALL go to DRAIN and keep the old imem_addr.
REQ-025 In DRAIN, imem_ack=1 SHALL discard the returned data, load imem_addr<=pc and enter REQ.
REQ-026 A redirect during DRAIN SHALL update pc only; the most recent redirect wins.
REQ-027 Redirect SHALL take priority over stall and over a same-cycle ack.

Reset
REQ-028 While rst_n=0, the unit SHALL hold state=REQ, pc=RESET_PC+4, imem_addr=RESET_PC, valid=0, and instr=pc_out=0, so that the decoded fields are 0.
REQ-029 Reset asserted mid-request SHALL abandon the request; any imem_ack during reset SHALL be ignored.

Configuration
REQ-030 With IFETCH_COUNT_EN defined, the unit SHALL provide output fetch_count (32 bits, reset 0).
REQ-031 fetch_count SHALL increment by 1 on each instruction load per REQ-017, and SHALL wrap at 2^32.
REQ-032 Discarded responses SHALL NOT increment fetch_count.
REQ-033 Without IFETCH_COUNT_EN, the fetch_count port and its register SHALL be absent.

Structure
REQ-034 Shared package mips_pkg SHALL hold the fetch state enumeration, the instruction field bit positions, the default RESET_PC and NOP (32'h0).
REQ-035 The IF/ID register (instr, pc_out, valid, with load/clear/hold controls) SHALL be a sub-module named if_id_reg.

Verification
REQ-036 Scenario 1: release reset with RESET_PC=0 and imem_ack=1 on the first request -> imem_addr=0, then valid=1, instr=rdata, pc_out=0, with the next request at 0x4.
REQ-037 Scenario 2: instr=0x8C28_0004 held with stall=1 for 3 cycles -> opcode=0x23, rs=1, rt=8, imm=0x0004, all stable, imem_req=0.
REQ-038 Scenario 3: redirect to 0x0000_0103 in HOLD -> valid=0 next cycle, imem_addr=0x100.
REQ-039 Scenario 4: redirect to 0x200 in REQ with ack delayed 2 cycles -> DRAIN keeps the old address, the data is discarded, then imem_addr=0x200 and valid=0 until its ack.
REQ-040 Scenario 5: fetch at 0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-041 Scenario 6 (IFETCH_COUNT_EN): 4 loads and 1 discarded response -> fetch_count=4; asserting rst_n=0 mid-request -> fetch_count=0, valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the instruction fetch slice: fetch
//                FSM state encoding, instruction field bit positions, the
//                default reset PC, the NOP encoding and a word-align helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch FSM states. REQ: request outstanding. HOLD: live instruction
    // parked in IF/ID. DRAIN: a redirect arrived while a request was in
    // flight, so its response must be swallowed.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;

    // Instruction field bit positions (MIPS-style encoding)
    localparam int c_OPCODE_HI = 31;
    localparam int c_OPCODE_LO = 26;
    localparam int c_RS_HI     = 25;
    localparam int c_RS_LO     = 21;
    localparam int c_RT_HI     = 20;
    localparam int c_RT_LO     = 16;
    localparam int c_RD_HI     = 15;
    localparam int c_RD_LO     = 11;
    localparam int c_FUNCT_HI  = 5;
    localparam int c_FUNCT_LO  = 0;
    localparam int c_IMM_HI    = 15;
    localparam int c_IMM_LO    = 0;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register holding the fetched instruction,
//                its address and a valid flag.
//                Load has priority over clear; with neither asserted the
//                register holds.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                i_load           - capture i_instr/i_pc and set valid
//                i_clear          - drop valid (contents are kept)
//                i_instr, i_pc    - incoming instruction word and address
//                o_instr, o_pc    - registered instruction and address
//                o_valid          - live-instruction flag
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= c_NOP;
            r_pc    <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Single-outstanding-request instruction fetch unit with
//                stall, branch redirect and response draining.
//  Parameters  : RESET_PC       - first fetch address after reset
//  Build macro : IFETCH_COUNT_EN - adds the fetch_count output/counter
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                imem_req/addr/ack/rdata    - instruction memory handshake
//                stall                      - hold current instruction
//                redirect_valid/redirect_pc - branch/jump redirect
//                valid, instr, pc_out       - IF/ID register outputs
//                opcode/funct/rs/rt/rd/imm  - decoded fields of instr
//                fetch_count (optional)     - count of loaded instructions
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm
`ifdef IFETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_addr;
    logic [31:0]  w_addr_next;
    logic [31:0]  w_target;
    logic         w_load;
    logic         w_clear;

    assign w_target = word_align(redirect_pc);

    // ------------------------------------------------------------------
    // State, next-PC and request-address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC + 32'd4;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Redirect is checked first everywhere so that it
    // wins over both stall and a same-cycle acknowledge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_next = w_target;
                    w_clear   = 1'b1;
                    if (imem_ack) begin
                        // Response is stale: drop it and refetch at target
                        w_addr_next = w_target;
                    end else begin
                        // Request still in flight: address must stay put
                        // until its response is swallowed
                        w_state_next = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    w_load       = 1'b1;
                    w_pc_next    = r_addr + 32'd4;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc_next    = w_target;
                    w_addr_next  = w_target;
                    w_clear      = 1'b1;
                    w_state_next = S_REQ;
                end else if (!stall) begin
                    w_addr_next  = r_pc;
                    w_clear      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    w_pc_next = w_target;
                    w_clear   = 1'b1;
                end
                if (imem_ack) begin
                    // Use the freshest target if a redirect lands alongside
                    w_addr_next  = redirect_valid ? w_target : r_pc;
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    assign imem_req  = (r_state != S_HOLD);
    assign imem_addr = r_addr;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_addr),
        .o_instr (instr),
        .o_pc    (pc_out),
        .o_valid (valid)
    );

    // Decoded fields
    assign opcode = instr[c_OPCODE_HI:c_OPCODE_LO];
    assign rs     = instr[c_RS_HI:c_RS_LO];
    assign rt     = instr[c_RT_HI:c_RT_LO];
    assign rd     = instr[c_RD_HI:c_RD_LO];
    assign funct  = instr[c_FUNCT_HI:c_FUNCT_LO];
    assign imm    = instr[c_IMM_HI:c_IMM_LO];

`ifdef IFETCH_COUNT_EN
    // Counts only real loads; discarded responses never assert w_load
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Loaded responses
//                are pushed to a scoreboard queue and popped when valid
//                rises; the bench tracks the expected fetch address itself.
//  Build macro : IFETCH_COUNT_EN - also checks fetch_count
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
`ifdef IFETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid          (valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .funct          (funct),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .imm            (imm)
`ifdef IFETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count();
`ifdef IFETCH_COUNT_EN
        check_eq("fetch_count", fetch_count, exp_cnt);
`endif
    endtask

    // Serve one request at exp_pc after 'delay' idle cycles; the response
    // is expected to be loaded (no redirect). Leaves the DUT in HOLD.
    task automatic fetch(input logic [31:0] data, input int delay);
        logic [63:0] e;
        check_eq("req_pending", {31'b0, imem_req}, 32'd1);
        check_eq("req_addr", imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            step();
            check_eq("addr_stable", imem_addr, exp_pc);
            check_eq("valid_wait", {31'b0, valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb_q.push_back({data, exp_pc});
        step();
        imem_ack = 1'b0;
        exp_pc   = exp_pc + 32'd4;
        exp_cnt  = exp_cnt + 32'd1;
        check_eq("valid_load", {31'b0, valid}, 32'd1);
        check_eq("req_hold", {31'b0, imem_req}, 32'd0);
        e = sb_q.pop_front();
        check_eq("instr", instr, e[63:32]);
        check_eq("pc_out", pc_out, e[31:0]);
        check_count();
    endtask

    // Release stall for one cycle: HOLD -> REQ at the next sequential PC.
    task automatic resume();
        stall = 1'b0;
        step();
        stall = 1'b1;
        check_eq("resume_valid", {31'b0, valid}, 32'd0);
        check_eq("resume_req", {31'b0, imem_req}, 32'd1);
        check_eq("resume_addr", imem_addr, exp_pc);
    endtask

    task automatic redirect_hold(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        exp_pc = {tgt[31:2], 2'b00};
        check_eq("redir_valid", {31'b0, valid}, 32'd0);
        check_eq("redir_req", {31'b0, imem_req}, 32'd1);
        check_eq("redir_addr", imem_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a spurious ack that must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        step();
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'd1);
        check_eq("rst_valid", {31'b0, valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_opcode", {26'b0, opcode}, 32'h0);
        check_count();
        imem_ack = 1'b0;
        rst_n    = 1'b1;

        // Scenario 1: immediate ack on the first request
        exp_pc = 32'h0;
        fetch(32'h8C28_0004, 0);

        // Scenario 2: stall holds everything
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_opcode", {26'b0, opcode}, 32'h23);
            check_eq("stall_rs", {27'b0, rs}, 32'd1);
            check_eq("stall_rt", {27'b0, rt}, 32'd8);
            check_eq("stall_imm", {16'b0, imm}, 32'h0004);
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
            check_eq("stall_valid", {31'b0, valid}, 32'd1);
            check_eq("stall_instr", instr, 32'h8C28_0004);
        end
        resume();

        // R-type fetch with a delayed ack
        fetch(32'h012A_4020, 2);
        check_eq("rtype_rd", {27'b0, rd}, 32'd8);
        check_eq("rtype_funct", {26'b0, funct}, 32'h20);

        // Scenario 3: redirect in HOLD, low bits dropped
        redirect_hold(32'h0000_0103);
        fetch(32'h2402_0001, 1);
        resume();

        // Scenario 4: redirect in REQ with ack still outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check_eq("drain_addr0", imem_addr, exp_pc);
        check_eq("drain_req", {31'b0, imem_req}, 32'd1);
        check_eq("drain_valid", {31'b0, valid}, 32'd0);
        step();
        check_eq("drain_addr1", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        exp_pc   = 32'h0000_0200;
        check_eq("post_drain_addr", imem_addr, exp_pc);
        check_eq("post_drain_valid", {31'b0, valid}, 32'd0);
        step();
        check_eq("post_drain_valid2", {31'b0, valid}, 32'd0);
        fetch(32'hAC28_0008, 0);
        resume();

        // Redirect with a same-cycle ack: data discarded, refetch at target
        imem_ack       = 1'b1;
        imem_rdata     = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = 32'h0000_0300;
        check_eq("ackredir_valid", {31'b0, valid}, 32'd0);
        check_eq("ackredir_addr", imem_addr, exp_pc);
        check_eq("ackredir_req", {31'b0, imem_req}, 32'd1);
        fetch(32'h1000_FFFF, 0);

        // Redirect beats stall
        redirect_hold(32'h0000_0400);
        fetch(32'h3C08_ABCD, 0);

        // Scenario 5: address wrap
        redirect_hold(32'hFFFF_FFFF);
        fetch(32'h0800_0000, 0);
        resume();
        check_eq("wrap_addr", imem_addr, 32'h0000_0000);

        // Two redirects during DRAIN: the later one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        step();
        redirect_pc = 32'h0000_0600;
        step();
        redirect_valid = 1'b0;
        check_eq("drain2_addr", imem_addr, 32'h0000_0000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_ack = 1'b0;
        exp_pc   = 32'h0000_0600;
        check_eq("drain2_target", imem_addr, exp_pc);
        check_eq("drain2_valid", {31'b0, valid}, 32'd0);
        fetch(32'h3C01_1234, 0);
        check_count();
        resume();

        // Reset asserted mid-request
        step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_addr", imem_addr, 32'h0);
        check_eq("midrst_valid", {31'b0, valid}, 32'd0);
        check_eq("midrst_req", {31'b0, imem_req}, 32'd1);
        check_eq("midrst_instr", instr, 32'h0);
        exp_cnt = 32'h0;
        check_count();
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        check_eq("midrst_ack_ignored", {31'b0, valid}, 32'd0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        exp_pc   = 32'h0;
        fetch(32'h2000_0001, 1);
        resume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
